// File: rtl/insn_fetch.sv
// Instruction fetch stage: 1-cycle program memory reads feeding a prefetch FIFO toward decode.
// Define FETCH_PREFETCH_EN for a DEPTH-entry prefetch buffer; otherwise a single entry is used.
module insn_fetch #(
  parameter int          DEPTH    = 2,
  parameter logic [15:0] RESET_IP = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_rdata,
  output logic [15:0] insn,
  output logic [15:0] insn_ip,
  output logic        insn_valid,
  input  logic        insn_ready,
  input  logic        load_ip,
  input  logic [15:0] new_ip,
  output logic [15:0] fetch_ip
);

`ifdef FETCH_PREFETCH_EN
  localparam int EFF = DEPTH;
`else
  // Single-entry build: DEPTH has no effect.
  localparam int EFF = 1 + 0 * DEPTH;
`endif
  localparam int          PW       = (EFF > 1) ? $clog2(EFF) : 1;
  localparam int          SLOTS    = 1 << PW;
  localparam int          CW       = $clog2(EFF) + 1;
  localparam int          AW       = CW + 1;
  localparam logic [15:0] START_IP = {RESET_IP[15:1], 1'b0};

  logic [15:0]   fetch_ip_r;
  logic [15:0]   infl_addr_r;
  logic          infl_r;
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [15:0]   data_r [SLOTS];
  logic [15:0]   addr_r [SLOTS];

  logic          pop_s;
  logic          fill_s;
  logic          issue_s;
  logic [AW-1:0] level_s;
  logic          unused_bit_s;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    if (p == PW'(EFF - 1)) begin
      ptr_next = {PW{1'b0}};
    end else begin
      ptr_next = p + PW'(1);
    end
  endfunction

  // Handshake, kill and issue decisions for the current cycle.
  always_comb begin
    pop_s   = insn_valid & insn_ready & ~load_ip;
    fill_s  = infl_r & ~load_ip;
    level_s = AW'(count_r) + AW'(infl_r) - AW'(pop_s);
    issue_s = ~rst & ~load_ip & (level_s < AW'(EFF));
  end

  assign unused_bit_s = new_ip[0];
  assign insn_valid   = (count_r != CW'(0));
  assign insn         = data_r[rd_ptr_r];
  assign insn_ip      = addr_r[rd_ptr_r];
  assign mem_rd       = issue_s;
  assign mem_addr     = fetch_ip_r;
  assign fetch_ip     = fetch_ip_r;

  // Fetch pointer, in-flight tracking and FIFO state; a redirect flushes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_ip_r  <= START_IP;
      infl_addr_r <= 16'h0000;
      infl_r      <= 1'b0;
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      count_r     <= CW'(0);
      for (int i = 0; i < SLOTS; i++) begin
        data_r[i] <= 16'h0000;
        addr_r[i] <= 16'h0000;
      end
    end else if (load_ip) begin
      fetch_ip_r <= {new_ip[15:1], 1'b0};
      infl_r     <= 1'b0;
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      count_r    <= CW'(0);
    end else begin
      if (issue_s) begin
        fetch_ip_r <= fetch_ip_r + 16'd2;
      end
      infl_r      <= issue_s;
      infl_addr_r <= fetch_ip_r;
      if (fill_s) begin
        data_r[wr_ptr_r] <= mem_rdata;
        addr_r[wr_ptr_r] <= infl_addr_r;
        wr_ptr_r         <= ptr_next(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_next(rd_ptr_r);
      end
      count_r <= count_r + CW'(fill_s) - CW'(pop_s);
    end
  end

endmodule

// File: tb/tb_insn_fetch.sv
// Directed self-checking bench for insn_fetch: stream, backpressure, redirect, wrap and async reset.
module tb_insn_fetch;

`ifdef FETCH_PREFETCH_EN
  localparam int EFF = 2;
`else
  localparam int EFF = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        insn_ready;
  logic        load_ip;
  logic [15:0] new_ip;

  logic [15:0] a_mem_addr, a_mem_rdata, a_insn, a_insn_ip, a_fetch_ip;
  logic        a_mem_rd, a_insn_valid;
  logic [15:0] b_mem_addr, b_mem_rdata, b_insn, b_insn_ip, b_fetch_ip;
  logic        b_mem_rd, b_insn_valid;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  insn_fetch #(.DEPTH(2), .RESET_IP(16'h0000)) dut_a (
    .clk(clk), .rst(rst), .mem_addr(a_mem_addr), .mem_rd(a_mem_rd), .mem_rdata(a_mem_rdata),
    .insn(a_insn), .insn_ip(a_insn_ip), .insn_valid(a_insn_valid), .insn_ready(insn_ready),
    .load_ip(load_ip), .new_ip(new_ip), .fetch_ip(a_fetch_ip));

  insn_fetch #(.DEPTH(2), .RESET_IP(16'hfffc)) dut_b (
    .clk(clk), .rst(rst), .mem_addr(b_mem_addr), .mem_rd(b_mem_rd), .mem_rdata(b_mem_rdata),
    .insn(b_insn), .insn_ip(b_insn_ip), .insn_valid(b_insn_valid), .insn_ready(insn_ready),
    .load_ip(load_ip), .new_ip(new_ip), .fetch_ip(b_fetch_ip));

  // Program memories: word at A is A^5a5a, returned one cycle after the strobe.
  initial begin
    a_mem_rdata = 16'hdead;
    b_mem_rdata = 16'hdead;
  end
  always @(posedge clk) begin
    if (a_mem_rd) a_mem_rdata <= a_mem_addr ^ 16'h5a5a;
    if (b_mem_rd) b_mem_rdata <= b_mem_addr ^ 16'h5a5a;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Hold reset for one edge, release it; returns inside cycle 0.
  task automatic start_run(input logic ready);
    rst = 1'b1;
    insn_ready = ready;
    load_ip = 1'b0;
    new_ip = 16'h0000;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    insn_ready = 1'b1;
    load_ip = 1'b0;
    new_ip = 16'h0000;
    step();
    compared++;
    if (a_insn_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b want 0", a_insn_valid); end
    compared++;
    if (a_insn !== 16'h0000) begin mismatched++; $display("FAIL reset_insn: got %h want 0000", a_insn); end
    compared++;
    if (a_insn_ip !== 16'h0000) begin mismatched++; $display("FAIL reset_insn_ip: got %h want 0000", a_insn_ip); end
    compared++;
    if (a_mem_rd !== 1'b0) begin mismatched++; $display("FAIL reset_mem_rd: got %b want 0", a_mem_rd); end
    compared++;
    if (a_fetch_ip !== 16'h0000) begin mismatched++; $display("FAIL reset_fetch_ip_a: got %h want 0000", a_fetch_ip); end
    compared++;
    if (b_fetch_ip !== 16'hfffc) begin mismatched++; $display("FAIL reset_fetch_ip_b: got %h want fffc", b_fetch_ip); end
    rst = 1'b0;
    #1;
    compared++;
    if (a_mem_rd !== 1'b1 || a_mem_addr !== 16'h0000) begin
      mismatched++; $display("FAIL first_issue: got rd=%b addr=%h want rd=1 addr=0000", a_mem_rd, a_mem_addr);
    end
  endtask

  task automatic test_stream;
    logic        exp_v, exp_rd;
    logic [15:0] exp_ip, exp_b_addr;
    start_run(1'b1);
    for (int k = 0; k < 10; k++) begin
      exp_v      = (EFF == 2) ? (k >= 2) : (k >= 2 && (k % 2) == 0);
      exp_ip     = (EFF == 2) ? 16'(2 * (k - 2)) : 16'(k - 2);
      exp_rd     = (EFF == 2) ? 1'b1 : ((k % 2) == 0);
      exp_b_addr = 16'hfffc + ((EFF == 2) ? 16'(2 * k) : 16'(k));
      compared++;
      if (a_insn_valid !== exp_v) begin
        mismatched++; $display("FAIL stream_valid c%0d: got %b want %b", k, a_insn_valid, exp_v);
      end
      if (exp_v) begin
        compared++;
        if (a_insn_ip !== exp_ip || a_insn !== (exp_ip ^ 16'h5a5a)) begin
          mismatched++;
          $display("FAIL stream_word c%0d: got ip=%h insn=%h want ip=%h insn=%h", k, a_insn_ip, a_insn, exp_ip, exp_ip ^ 16'h5a5a);
        end
        compared++;
        if (b_insn_ip !== 16'hfffc + exp_ip || b_insn !== ((16'hfffc + exp_ip) ^ 16'h5a5a)) begin
          mismatched++;
          $display("FAIL wrap_word c%0d: got ip=%h insn=%h want ip=%h", k, b_insn_ip, b_insn, 16'hfffc + exp_ip);
        end
      end
      compared++;
      if (b_mem_rd !== exp_rd || (exp_rd && b_mem_addr !== exp_b_addr)) begin
        mismatched++;
        $display("FAIL wrap_fetch c%0d: got rd=%b addr=%h want rd=%b addr=%h", k, b_mem_rd, b_mem_addr, exp_rd, exp_b_addr);
      end
      step();
    end
  endtask

  task automatic test_backpressure;
    int          rd_count = 0;
    int          acc = 0;
    logic [15:0] exp_ip = 16'h0000;
    start_run(1'b0);
    for (int k = 0; k < 10; k++) begin
      rd_count += int'(a_mem_rd);
      if (k >= 2) begin
        compared++;
        if (a_insn_valid !== 1'b1 || a_insn !== 16'h5a5a || a_insn_ip !== 16'h0000) begin
          mismatched++;
          $display("FAIL bp_hold c%0d: got v=%b insn=%h ip=%h want v=1 insn=5a5a ip=0000", k, a_insn_valid, a_insn, a_insn_ip);
        end
      end
      step();
    end
    compared++;
    if (rd_count !== EFF) begin mismatched++; $display("FAIL bp_reads: got %0d want %0d", rd_count, EFF); end
    insn_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (a_insn_valid) begin
        compared++;
        if (a_insn_ip !== exp_ip || a_insn !== (exp_ip ^ 16'h5a5a)) begin
          mismatched++; $display("FAIL bp_release: got ip=%h insn=%h want ip=%h", a_insn_ip, a_insn, exp_ip);
        end
        exp_ip += 16'd2;
        acc++;
      end
      step();
    end
    compared++;
    if (acc !== ((EFF == 2) ? 8 : 4)) begin
      mismatched++; $display("FAIL bp_accepts: got %0d want %0d", acc, (EFF == 2) ? 8 : 4);
    end
  endtask

  task automatic test_redirect;
    start_run(1'b1);
    repeat (4) step();
    load_ip = 1'b1;
    new_ip = 16'h0123;
    #1;
    compared++;
    if (a_mem_rd !== 1'b0) begin mismatched++; $display("FAIL redir_t_rd: got %b want 0", a_mem_rd); end
    step();
    load_ip = 1'b0;
    #1;
    compared++;
    if (a_insn_valid !== 1'b0) begin mismatched++; $display("FAIL redir_t1_valid: got %b want 0", a_insn_valid); end
    compared++;
    if (a_mem_rd !== 1'b1 || a_mem_addr !== 16'h0122 || a_fetch_ip !== 16'h0122) begin
      mismatched++;
      $display("FAIL redir_t1_issue: got rd=%b addr=%h fip=%h want rd=1 addr=0122 fip=0122", a_mem_rd, a_mem_addr, a_fetch_ip);
    end
    step();
    compared++;
    if (a_insn_valid !== 1'b0) begin mismatched++; $display("FAIL redir_t2_valid: got %b want 0", a_insn_valid); end
    step();
    compared++;
    if (a_insn_valid !== 1'b1 || a_insn_ip !== 16'h0122 || a_insn !== 16'h5b78) begin
      mismatched++;
      $display("FAIL redir_t3: got v=%b ip=%h insn=%h want v=1 ip=0122 insn=5b78", a_insn_valid, a_insn_ip, a_insn);
    end
    step();
    compared++;
    if (a_insn_valid !== (EFF == 2) || (a_insn_valid && a_insn_ip !== 16'h0124)) begin
      mismatched++; $display("FAIL redir_t4: got v=%b ip=%h want v=%b ip=0124", a_insn_valid, a_insn_ip, EFF == 2);
    end
  endtask

  task automatic test_back_to_back;
    start_run(1'b1);
    repeat (3) step();
    load_ip = 1'b1;
    new_ip = 16'h0123;
    step();
    new_ip = 16'h0400;
    step();
    load_ip = 1'b0;
    #1;
    compared++;
    if (a_insn_valid !== 1'b0 || a_mem_rd !== 1'b1 || a_mem_addr !== 16'h0400) begin
      mismatched++;
      $display("FAIL b2b_t1: got v=%b rd=%b addr=%h want v=0 rd=1 addr=0400", a_insn_valid, a_mem_rd, a_mem_addr);
    end
    step();
    compared++;
    if (a_insn_valid !== 1'b0) begin mismatched++; $display("FAIL b2b_t2_valid: got %b want 0", a_insn_valid); end
    step();
    compared++;
    if (a_insn_valid !== 1'b1 || a_insn_ip !== 16'h0400 || a_insn !== 16'h5e5a) begin
      mismatched++;
      $display("FAIL b2b_t3: got v=%b ip=%h insn=%h want v=1 ip=0400 insn=5e5a", a_insn_valid, a_insn_ip, a_insn);
    end
  endtask

  task automatic test_reset_mid;
    start_run(1'b1);
    repeat (3) step();
    #2;
    rst = 1'b1;
    #1;
    compared++;
    if (a_insn_valid !== 1'b0 || a_mem_rd !== 1'b0 || a_insn_ip !== 16'h0000) begin
      mismatched++;
      $display("FAIL rstmid_async: got v=%b rd=%b ip=%h want v=0 rd=0 ip=0000", a_insn_valid, a_mem_rd, a_insn_ip);
    end
    #1;
    rst = 1'b0;
    #1;
    compared++;
    if (a_mem_rd !== 1'b1 || a_mem_addr !== 16'h0000 || a_fetch_ip !== 16'h0000) begin
      mismatched++;
      $display("FAIL rstmid_restart: got rd=%b addr=%h fip=%h want rd=1 addr=0000 fip=0000", a_mem_rd, a_mem_addr, a_fetch_ip);
    end
    step();
    compared++;
    if (a_insn_valid !== 1'b0) begin mismatched++; $display("FAIL rstmid_c1_valid: got %b want 0", a_insn_valid); end
    step();
    compared++;
    if (a_insn_valid !== 1'b1 || a_insn_ip !== 16'h0000 || a_insn !== 16'h5a5a) begin
      mismatched++;
      $display("FAIL rstmid_c2: got v=%b ip=%h insn=%h want v=1 ip=0000 insn=5a5a", a_insn_valid, a_insn_ip, a_insn);
    end
  endtask

  initial begin
    rst = 1'b1;
    insn_ready = 1'b0;
    load_ip = 1'b0;
    new_ip = 16'h0000;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
